// File: rtl/saladin_pkg.sv
// Shared sizing helpers for the bank scheduling slice: kernel count,
// index widths, row width and the kernel-to-bank mapping.
package saladin_pkg;

  // Number of scheduling kernels (one per bank read port).
  function automatic int nkernels(input int nbanks, input int nports);
    return nbanks * nports;
  endfunction

  // Width needed to index n items; never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row address width once the bank-select bits are stripped off.
  function automatic int row_width(input int addr_w, input int nbanks);
    return addr_w - id_width(nbanks);
  endfunction

  // Bank served by kernel k (kernel k = bank*nports + port).
  function automatic int kernel_bank(input int k, input int nports);
    return k / nports;
  endfunction

endpackage

// File: rtl/response_tag_pipe.sv
// Per-kernel tag pipeline: carries {valid, consumer id} alongside an issued
// read so that the tail lines up with the cycle mem_rdata is valid.
module response_tag_pipe #(
  parameter int MEM_LATENCY = 2,
  parameter int CW          = 3,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CW-1:0]     in_id,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cap_valid,
  output logic [CW-1:0]     cap_id,
  output logic [DATA_W-1:0] cap_data
);

  logic [MEM_LATENCY-1:0]         valid_q, valid_d;
  logic [MEM_LATENCY-1:0][CW-1:0] id_q, id_d;

  // Shift the tag one stage per cycle; stage 0 takes the registered issue.
  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    valid_d[0] = in_valid;
    id_d[0]    = in_id;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
  end

  // Tag stage registers; reset flushes every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  // Tail stage coincides with valid read data, which is handed up for capture.
  assign cap_valid = valid_q[MEM_LATENCY-1];
  assign cap_id    = id_q[MEM_LATENCY-1];
  assign cap_data  = mem_rdata;

endmodule

// File: rtl/bank_response_router.sv
// Consumer-side router: one request slot per consumer, grant validation and
// issue to bank ports, and return of read data to the owning consumer.
module bank_response_router
  import saladin_pkg::*;
#(
  parameter int NCONSUMERS  = 8,
  parameter int NBANKS      = 4,
  parameter int NPORTS      = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  localparam int CW       = id_width(NCONSUMERS),
  localparam int BW       = id_width(NBANKS),
  localparam int NKERNELS = nkernels(NBANKS, NPORTS),
  localparam int RW       = row_width(ADDR_W, NBANKS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCONSUMERS-1:0]        req_valid,
  input  logic [NCONSUMERS*ADDR_W-1:0] req_addr,
  output logic [NCONSUMERS-1:0]        req_ready,
  output logic [NCONSUMERS-1:0]        pending,
  output logic [NCONSUMERS*BW-1:0]     pending_bank,
  input  logic [NKERNELS-1:0]          grant_valid,
  input  logic [NKERNELS*CW-1:0]       grant_consumer,
  output logic [NKERNELS-1:0]          mem_en,
  output logic [NKERNELS*RW-1:0]       mem_addr,
  input  logic [NKERNELS*DATA_W-1:0]   mem_rdata,
  output logic [NCONSUMERS-1:0]        resp_valid,
  output logic [NCONSUMERS*DATA_W-1:0] resp_data,
  output logic                         grant_error
);

  logic [NCONSUMERS-1:0][ADDR_W-1:0] req_addr_a;
  logic [NKERNELS-1:0][CW-1:0]       grant_consumer_a;
  logic [NKERNELS-1:0][DATA_W-1:0]   mem_rdata_a;

  logic [NCONSUMERS-1:0]             slot_held_q, slot_held_d;
  logic [NCONSUMERS-1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [NKERNELS-1:0]               mem_en_q, mem_en_d;
  logic [NKERNELS-1:0][RW-1:0]       mem_addr_q, mem_addr_d;
  logic [NKERNELS-1:0][CW-1:0]       mem_id_q, mem_id_d;
  logic [NCONSUMERS-1:0]             resp_valid_q, resp_valid_d;
  logic [NCONSUMERS-1:0][DATA_W-1:0] resp_data_q, resp_data_d;
  logic                              grant_error_q, grant_error_d;

  logic [NCONSUMERS-1:0]             taken_s;
  logic                              drop_s;
  logic [CW-1:0]                     gc_s;
  logic [NCONSUMERS-1:0][BW-1:0]     pending_bank_s;

  logic [NKERNELS-1:0]               cap_valid_s;
  logic [NKERNELS-1:0][CW-1:0]       cap_id_s;
  logic [NKERNELS-1:0][DATA_W-1:0]   cap_data_s;

  assign req_addr_a       = req_addr;
  assign grant_consumer_a = grant_consumer;
  assign mem_rdata_a      = mem_rdata;

  // Validate grants in ascending kernel order; the first valid grant per consumer wins.
  always_comb begin
    taken_s    = '0;
    drop_s     = 1'b0;
    gc_s       = '0;
    mem_en_d   = '0;
    mem_addr_d = '0;
    mem_id_d   = '0;
    for (int k = 0; k < NKERNELS; k++) begin
      gc_s = grant_consumer_a[k];
      if (grant_valid[k]) begin
        if (slot_held_q[gc_s] && !taken_s[gc_s] &&
            (slot_addr_q[gc_s][BW-1:0] == BW'(kernel_bank(k, NPORTS)))) begin
          taken_s[gc_s] = 1'b1;
          mem_en_d[k]   = 1'b1;
          mem_addr_d[k] = slot_addr_q[gc_s][ADDR_W-1:BW];
          mem_id_d[k]   = gc_s;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        mem_en_d[k] = 1'b0;
      end
    end
  end

  // Slot bookkeeping: honored grants empty a slot, empty slots accept new requests.
  always_comb begin
    slot_held_d   = slot_held_q & ~taken_s;
    slot_addr_d   = slot_addr_q;
    grant_error_d = grant_error_q | drop_s;
    for (int c = 0; c < NCONSUMERS; c++) begin
      if (req_valid[c] && !slot_held_q[c]) begin
        slot_held_d[c] = 1'b1;
        slot_addr_d[c] = req_addr_a[c];
      end else begin
        slot_addr_d[c] = slot_addr_q[c];
      end
    end
  end

  // Route each kernel's returning data to its owner; one issue per consumer per cycle means no collisions.
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    for (int k = 0; k < NKERNELS; k++) begin
      if (cap_valid_s[k]) begin
        resp_valid_d[cap_id_s[k]] = 1'b1;
        resp_data_d[cap_id_s[k]]  = cap_data_s[k];
      end else begin
        resp_valid_d = resp_valid_d;
      end
    end
  end

  // Bank-select bits of each held address, presented to the scheduler.
  always_comb begin
    pending_bank_s = '0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      pending_bank_s[c] = slot_addr_q[c][BW-1:0];
    end
  end

  // State and output registers; reset discards held and in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_held_q   <= '0;
      slot_addr_q   <= '0;
      mem_en_q      <= '0;
      mem_addr_q    <= '0;
      mem_id_q      <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      grant_error_q <= 1'b0;
    end else begin
      slot_held_q   <= slot_held_d;
      slot_addr_q   <= slot_addr_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_id_q      <= mem_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      grant_error_q <= grant_error_d;
    end
  end

  for (genvar k = 0; k < NKERNELS; k++) begin : g_tag
    response_tag_pipe #(
      .MEM_LATENCY(MEM_LATENCY),
      .CW         (CW),
      .DATA_W     (DATA_W)
    ) u_tag (
      .clk      (clk),
      .reset    (reset),
      .in_valid (mem_en_q[k]),
      .in_id    (mem_id_q[k]),
      .mem_rdata(mem_rdata_a[k]),
      .cap_valid(cap_valid_s[k]),
      .cap_id   (cap_id_s[k]),
      .cap_data (cap_data_s[k])
    );
  end

  assign req_ready    = ~slot_held_q;
  assign pending      = slot_held_q;
  assign pending_bank = pending_bank_s;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign grant_error  = grant_error_q;

endmodule

// File: tb/tb_bank_response_router.sv
// Directed bench for bank_response_router (8 consumers, 4 banks x 2 ports,
// latency 2). Inputs change and outputs are sampled at the falling edge.
module tb_bank_response_router;

  logic                  clk;
  logic                  reset;
  logic [7:0]            req_valid;
  logic [7:0][15:0]      req_addr;
  logic [7:0]            req_ready;
  logic [7:0]            pending;
  logic [7:0][1:0]       pending_bank;
  logic [7:0]            grant_valid;
  logic [7:0][2:0]       grant_consumer;
  logic [7:0]            mem_en;
  logic [7:0][13:0]      mem_addr;
  logic [7:0][31:0]      mem_rdata;
  logic [7:0]            resp_valid;
  logic [7:0][31:0]      resp_data;
  logic                  grant_error;

  int vectors;
  int miscompares;

  logic [15:0] bb_addr [4];
  logic [31:0] bb_data [4];

  bank_response_router #(
    .NCONSUMERS (8),
    .NBANKS     (4),
    .NPORTS     (2),
    .ADDR_W     (16),
    .DATA_W     (32),
    .MEM_LATENCY(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .pending       (pending),
    .pending_bank  (pending_bank),
    .grant_valid   (grant_valid),
    .grant_consumer(grant_consumer),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .grant_error   (grant_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid      = 8'h00;
    req_addr       = '0;
    grant_valid    = 8'h00;
    grant_consumer = '0;
    mem_rdata      = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bb_addr[0] = 16'h0007; bb_addr[1] = 16'h000B; bb_addr[2] = 16'h000F; bb_addr[3] = 16'h0013;
    bb_data[0] = 32'h5A5A0001; bb_data[1] = 32'h5A5A0002; bb_data[2] = 32'h5A5A0003; bb_data[3] = 32'h5A5A0004;
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);

    // ---- reset state
    apply_reset();
    chk("rst_req_ready",    64'(req_ready),    64'hFF);
    chk("rst_pending",      64'(pending),      64'h00);
    chk("rst_pending_bank", 64'(pending_bank), 64'h0000);
    chk("rst_mem_en",       64'(mem_en),       64'h00);
    chk("rst_resp_valid",   64'(resp_valid),   64'h00);
    chk("rst_resp_data7",   64'(resp_data[7]), 64'h0);
    chk("rst_grant_error",  64'(grant_error),  64'h0);

    // ---- single read: consumer 3, addr 0x0016 -> bank 2, row 5, kernel 4
    req_valid[3] = 1'b1; req_addr[3] = 16'h0016;
    tick();
    chk("sr_pending",   64'(pending),         64'h08);
    chk("sr_req_ready", 64'(req_ready),       64'hF7);
    chk("sr_pbank3",    64'(pending_bank[3]), 64'h2);
    req_valid = 8'h00; grant_valid[4] = 1'b1; grant_consumer[4] = 3'd3;
    tick();
    chk("sr_mem_en",    64'(mem_en),      64'h10);
    chk("sr_mem_addr4", 64'(mem_addr[4]), 64'h5);
    chk("sr_slot_free", 64'(pending),     64'h00);
    grant_valid = 8'h00; mem_rdata[4] = 32'h0BAD0002;
    tick();
    chk("sr_resp_c3",   64'(resp_valid), 64'h00);
    chk("sr_mem_en_lo", 64'(mem_en),     64'h00);
    mem_rdata[4] = 32'h0BAD0003;
    tick();
    chk("sr_resp_c4", 64'(resp_valid), 64'h00);
    mem_rdata[4] = 32'hCAFE0003;
    tick();
    chk("sr_resp_valid", 64'(resp_valid),   64'h08);
    chk("sr_resp_data",  64'(resp_data[3]), 64'hCAFE0003);
    mem_rdata[4] = 32'h0BAD0005;
    tick();
    chk("sr_resp_pulse", 64'(resp_valid),  64'h00);
    chk("sr_no_error",   64'(grant_error), 64'h0);

    // ---- wrong-bank grant: consumer 1 holds bank 0 row 4, granted on kernel 2 (bank 1)
    clear_inputs();
    req_valid[1] = 1'b1; req_addr[1] = 16'h0010;
    tick();
    req_valid = 8'h00; grant_valid[2] = 1'b1; grant_consumer[2] = 3'd1;
    tick();
    chk("wb_mem_en",      64'(mem_en),      64'h00);
    chk("wb_grant_error", 64'(grant_error), 64'h1);
    chk("wb_pending",     64'(pending),     64'h02);
    grant_valid = 8'h00; grant_valid[0] = 1'b1; grant_consumer[0] = 3'd1;
    tick();
    chk("wb_retry_en",   64'(mem_en),      64'h01);
    chk("wb_retry_addr", 64'(mem_addr[0]), 64'h4);
    chk("wb_retry_pend", 64'(pending),     64'h00);
    clear_inputs();
    tick(); tick(); tick(); tick();
    apply_reset();
    chk("wb_err_cleared", 64'(grant_error), 64'h0);

    // ---- double grant: kernels 0 and 1 both grant consumer 0 (bank 0 row 8)
    req_valid[0] = 1'b1; req_addr[0] = 16'h0020;
    tick();
    req_valid = 8'h00; grant_valid = 8'h03; grant_consumer[0] = 3'd0; grant_consumer[1] = 3'd0;
    tick();
    chk("dg_mem_en",      64'(mem_en),      64'h01);
    chk("dg_mem_addr0",   64'(mem_addr[0]), 64'h8);
    chk("dg_grant_error", 64'(grant_error), 64'h1);
    chk("dg_pending",     64'(pending),     64'h00);
    clear_inputs();
    tick(); tick(); tick(); tick();
    apply_reset();

    // ---- back-to-back: consumer 5 on bank 3 via kernel 6, 4 reads, grant every other cycle
    for (int c = 0; c < 12; c++) begin
      if (c == 2 || c == 4 || c == 6 || c == 8) begin
        chk("bb_mem_en",   64'(mem_en),      64'h40);
        chk("bb_mem_addr", 64'(mem_addr[6]), 64'(c / 2));
      end else begin
        chk("bb_mem_en_lo", 64'(mem_en), 64'h00);
      end
      if (c == 5 || c == 7 || c == 9 || c == 11) begin
        chk("bb_resp_valid", 64'(resp_valid),   64'h20);
        chk("bb_resp_data",  64'(resp_data[5]), 64'(bb_data[(c - 5) / 2]));
      end else begin
        chk("bb_resp_lo", 64'(resp_valid), 64'h00);
      end
      req_valid[5]      = (c % 2 == 0) && (c <= 6);
      req_addr[5]       = (c <= 6) ? bb_addr[c / 2] : 16'h0000;
      grant_valid[6]    = (c % 2 == 1) && (c <= 7);
      grant_consumer[6] = 3'd5;
      mem_rdata[6]      = (c == 4 || c == 6 || c == 8 || c == 10) ? bb_data[(c - 4) / 2]
                                                                  : (32'hDEAD0000 | 32'(c));
      tick();
    end
    chk("bb_pending",     64'(pending),     64'h00);
    chk("bb_grant_error", 64'(grant_error), 64'h0);

    // ---- reset mid-flight: consumer 2 issued on kernel 2, consumer 6 still held
    clear_inputs();
    req_valid[2] = 1'b1; req_addr[2] = 16'h0005;
    req_valid[6] = 1'b1; req_addr[6] = 16'h0002;
    tick();
    req_valid = 8'h00; grant_valid[2] = 1'b1; grant_consumer[2] = 3'd2;
    tick();
    chk("mf_mem_en",  64'(mem_en),  64'h04);
    chk("mf_pending", 64'(pending), 64'h40);
    grant_valid = 8'h00; mem_rdata[2] = 32'h77770002;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mf_mem_en_rst", 64'(mem_en), 64'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mf_no_resp", 64'(resp_valid), 64'h00);
    end
    chk("mf_req_ready", 64'(req_ready), 64'hFF);
    chk("mf_pending0",  64'(pending),   64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bank_response_router.md
# bank_response_router

Consumer-side counterpart of the round-robin scheduling kernel. Holds one outstanding read request per consumer and exposes it to the scheduler as a pending/target-bank vector. It turns each scheduler grant into a bank-port read, tracks the grant through the fixed memory latency, and returns the read data to the owning consumer. It sits between the consumers, the scheduler, and the NBANKS×NPORTS memory ports.

## Interface
- NCONSUMERS, 8: number of consumers; power of two; CW = $clog2(NCONSUMERS)
- NBANKS, 4: number of memory banks; power of two; BW = $clog2(NBANKS)
- NPORTS, 2: read ports per bank; NKERNELS = NBANKS*NPORTS; kernel k = bank*NPORTS + port
- ADDR_W, 16: consumer address width
- DATA_W, 32: read data width
- MEM_LATENCY, 2: cycles from mem_en to valid mem_rdata; must be ≥1
- clk  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NCONSUMERS  consumer c offers a request
- req_addr  in  NCONSUMERS*ADDR_W  request address; bank = addr[BW-1:0], row = addr[ADDR_W-1:BW]
- req_ready  out  NCONSUMERS  slot c empty; request accepted when valid&&ready
- pending  out  NCONSUMERS  slot c holds a request (to scheduler)
- pending_bank  out  NCONSUMERS*BW  target bank of slot c
- grant_valid  in  NKERNELS  scheduler grants kernel k this cycle
- grant_consumer  in  NKERNELS*CW  consumer granted on kernel k
- mem_en  out  NKERNELS  read strobe to bank port k
- mem_addr  out  NKERNELS*(ADDR_W-BW)  row address to bank port k
- mem_rdata  in  NKERNELS*DATA_W  read data, valid MEM_LATENCY cycles after mem_en
- resp_valid  out  NCONSUMERS  one-cycle pulse: resp_data for c valid
- resp_data  out  NCONSUMERS*DATA_W  returned data for c
- grant_error  out  1  sticky; set on any dropped grant

## Operation
- Slot c states: EMPTY → (req_valid&&req_ready) → HELD → (honored grant) → EMPTY. The slot latches req_addr on accept. req_ready = !pending.
- A grant on kernel k for consumer c is honored only if slot c is HELD and pending_bank[c] == k/NPORTS. Otherwise the grant is dropped: no mem_en, and grant_error is set.
- If several kernels grant the same consumer in one cycle, the lowest k is honored and the rest are dropped (grant_error set).
- Honored grant: mem_en[k] and mem_addr[k] = slot row are registered outputs asserted the cycle after the grant. The slot empties on the same edge, so the consumer may offer a new request that cycle.
- Tag pipeline: per kernel, a MEM_LATENCY-deep shift of {valid, consumer id} aligned with mem_en. When the tail valid is set, the block captures mem_rdata[k] and registers resp_valid/resp_data for that consumer on the next edge.
- A consumer has at most one issue per cycle and latency is fixed, so responses never collide. Response order per consumer equals issue order.
- A request accepted in the same cycle a grant names that consumer is not honored, because the slot was not yet HELD; that grant is dropped.

## Timing
- Reset values: req_ready all 1, pending 0, pending_bank 0, mem_en 0, mem_addr 0, resp_valid 0, resp_data 0, grant_error 0. The tag pipeline is flushed.
- Accept at edge T → pending=1 after T. Grant sampled at edge T+g → mem_en high in cycle T+g+1. Data captured MEM_LATENCY cycles later, and resp_valid pulses one cycle after capture.
- Grant-to-resp_valid latency = MEM_LATENCY+2 cycles.
- Reset mid-operation discards all held and in-flight requests. No resp_valid is asserted for them after reset deasserts.
- grant_error clears only on reset.

## Structure
- Shared package saladin_pkg: NKERNELS and width helpers (CW, BW, row width), plus a kernel→bank function (k/NPORTS).
- Sub-module response_tag_pipe: one instance per kernel, parameterized by MEM_LATENCY and CW. It handles the valid/id shift and data capture.
- All other logic is flat in bank_response_router.

## Test plan
- Reset: hold reset 2 cycles → req_ready=8'hFF, pending=0, mem_en=0, resp_valid=0, grant_error=0.
- Single read: consumer 3 requests addr 16'h0016 (bank 2, row 5). Grant kernel 4 to consumer 3 → mem_en[4]=1 and mem_addr[4]=5 the next cycle. With mem_rdata[4]=32'hCAFE0003, resp_valid[3] pulses with resp_data=32'hCAFE0003 exactly MEM_LATENCY+2 cycles after the grant.
- Wrong-bank grant: consumer 1 holds a bank-0 request and receives a grant on kernel 2 (bank 1) → no mem_en, grant_error=1, pending[1] stays 1.
- Double grant: kernels 0 and 1 both grant consumer 0 → only mem_en[0] asserted, grant_error=1.
- Back-to-back: consumer 5 re-requests the cycle after issue, and is granted every other cycle for 4 reads → 4 resp_valid pulses in issue order with the matching data.
- Reset mid-flight: reset the cycle after mem_en → no resp_valid for 10 cycles after reset deasserts, and all slots are empty.
